// File: rtl/phase_strobe_gen.sv
`default_nettype none
// ============================================================================
// Module      : phase_strobe_gen
// Description : Multi-channel periodic strobe generator. A shared base counter
//               runs through one programmable period. Each channel derives a
//               level (phase offset + high width) and a one-cycle strobe on the
//               level's rising edge. All outputs are registered, latency 1.
// Revision    : 1.0 - initial release
// ============================================================================
module phase_strobe_gen #(
    parameter int NUM_CH = 2,
    parameter int CNT_W  = 8
) (
    input  logic                                         clk,
    input  logic                                         reset_n,
    input  logic                                         per_wr,
    input  logic                                         cfg_wr,
    input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] cfg_ch,
    input  logic [CNT_W-1:0]                             cfg_period,
    input  logic [CNT_W-1:0]                             cfg_phase,
    input  logic [CNT_W-1:0]                             cfg_high,
    input  logic                                         start,
    input  logic                                         stop,
    output logic                                         busy,
    output logic [NUM_CH-1:0]                            level,
    output logic [NUM_CH-1:0]                            strobe,
    output logic                                         cycle_tick,
    output logic                                         cfg_err
);

    localparam int c_ch_w = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_arm  = 2'd1;
    localparam logic [1:0] c_st_run  = 2'd2;

    localparam logic [CNT_W-1:0] c_def_period = CNT_W'(10);
    localparam logic [CNT_W-1:0] c_def_high   = CNT_W'(5);

    // State and counters
    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [CNT_W-1:0] r_base_cnt;
    logic             r_stop_pend;

    // Stored configuration
    logic [CNT_W-1:0] r_period;
    logic [CNT_W-1:0] r_phase [NUM_CH];
    logic [CNT_W-1:0] r_high  [NUM_CH];

    // Decode
    logic              w_cfg_ok;
    logic              w_start_eff;
    logic              w_any_wr;
    logic              w_last;
    logic              w_err;
    logic              w_wr_en;
    logic              w_end;
    logic              w_running;
    logic [CNT_W:0]    w_diff;
    logic [NUM_CH-1:0] w_level;
    logic [NUM_CH-1:0] w_strobe;

    // A stop in the same cycle cancels the start entirely, so the start is
    // neither evaluated nor treated as colliding with a config write.
    assign w_start_eff = start & ~stop;
    assign w_any_wr    = per_wr | cfg_wr;
    assign w_last      = (r_base_cnt == (r_period - CNT_W'(1)));
    assign w_running   = (r_state == c_st_run);
    assign busy        = (r_state != c_st_idle);

    // Validate the currently stored configuration (no subtraction, so a zero
    // period cannot underflow into a false pass).
    always_comb begin
        w_cfg_ok = (r_period >= CNT_W'(2));
        for (int i = 0; i < NUM_CH; i++) begin
            if ((r_high[i] == '0) || (r_high[i] >= r_period) || (r_phase[i] >= r_period)) begin
                w_cfg_ok = 1'b0;
            end
        end
    end

    // Next-state, error and write-enable decode
    always_comb begin
        w_state_nxt = r_state;
        w_err       = 1'b0;
        w_wr_en     = 1'b0;
        w_end       = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (w_start_eff) begin
                    w_err = w_any_wr | ~w_cfg_ok;
                    if (w_cfg_ok) begin
                        w_state_nxt = c_st_arm;
                    end
                end else begin
                    w_wr_en = 1'b1;
                end
            end
            c_st_arm: begin
                w_err       = w_any_wr;
                w_state_nxt = stop ? c_st_idle : c_st_run;
            end
            c_st_run: begin
                w_err = w_any_wr;
                if (w_last && (r_stop_pend || stop)) begin
                    w_end       = 1'b1;
                    w_state_nxt = c_st_idle;
                end
            end
            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Base counter: held at zero outside RUN, wraps at period-1 while running
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_base_cnt <= '0;
        end else if (w_running) begin
            r_base_cnt <= w_last ? '0 : (r_base_cnt + CNT_W'(1));
        end else begin
            r_base_cnt <= '0;
        end
    end

    // Remember a stop seen mid-period until the period completes
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stop_pend <= 1'b0;
        end else if (w_running && (w_state_nxt == c_st_run)) begin
            r_stop_pend <= r_stop_pend | stop;
        end else begin
            r_stop_pend <= 1'b0;
        end
    end

    // Configuration registers, writable only while idle and not starting
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_period <= c_def_period;
            for (int i = 0; i < NUM_CH; i++) begin
                r_phase[i] <= '0;
                r_high[i]  <= c_def_high;
            end
        end else if (w_wr_en) begin
            if (per_wr) begin
                r_period <= cfg_period;
            end
            if (cfg_wr) begin
                for (int i = 0; i < NUM_CH; i++) begin
                    if (cfg_ch == c_ch_w'(i)) begin
                        r_phase[i] <= cfg_phase;
                        r_high[i]  <= cfg_high;
                    end
                end
            end
        end
    end

    // Per-channel level and strobe from the distance past each phase offset
    always_comb begin
        w_diff   = '0;
        w_level  = '0;
        w_strobe = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (r_base_cnt >= r_phase[i]) begin
                w_diff = {1'b0, r_base_cnt} - {1'b0, r_phase[i]};
            end else begin
                w_diff = {1'b0, r_base_cnt} + {1'b0, r_period} - {1'b0, r_phase[i]};
            end
            w_level[i]  = (w_diff < {1'b0, r_high[i]});
            w_strobe[i] = (r_base_cnt == r_phase[i]);
        end
    end

    // Registered outputs; the final count of a stopped run only reports cycle_tick
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            level      <= '0;
            strobe     <= '0;
            cycle_tick <= 1'b0;
            cfg_err    <= 1'b0;
        end else begin
            level      <= (w_running && !w_end) ? w_level  : '0;
            strobe     <= (w_running && !w_end) ? w_strobe : '0;
            cycle_tick <= w_running && w_last;
            cfg_err    <= w_err;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_phase_strobe_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_phase_strobe_gen
// Description : Scoreboard bench for phase_strobe_gen. A reference model
//               counts run cycles and derives expected outputs with modulo
//               arithmetic; a monitor pops and compares every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_phase_strobe_gen;

    localparam int c_num_ch = 2;
    localparam int c_cnt_w  = 8;

    logic               clk = 1'b0;
    logic               reset_n = 1'b0;
    logic               per_wr = 1'b0;
    logic               cfg_wr = 1'b0;
    logic [0:0]         cfg_ch = '0;
    logic [c_cnt_w-1:0] cfg_period = '0;
    logic [c_cnt_w-1:0] cfg_phase = '0;
    logic [c_cnt_w-1:0] cfg_high = '0;
    logic               start = 1'b0;
    logic               stop = 1'b0;
    logic               busy;
    logic [c_num_ch-1:0] level;
    logic [c_num_ch-1:0] strobe;
    logic               cycle_tick;
    logic               cfg_err;

    typedef struct packed {
        logic       busy;
        logic [1:0] level;
        logic [1:0] strobe;
        logic       tick;
        logic       err;
    } exp_t;

    exp_t sb_q[$];
    int   tests = 0;
    int   fails = 0;
    event ev_async;

    phase_strobe_gen #(.NUM_CH(c_num_ch), .CNT_W(c_cnt_w)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .per_wr     (per_wr),
        .cfg_wr     (cfg_wr),
        .cfg_ch     (cfg_ch),
        .cfg_period (cfg_period),
        .cfg_phase  (cfg_phase),
        .cfg_high   (cfg_high),
        .start      (start),
        .stop       (stop),
        .busy       (busy),
        .level      (level),
        .strobe     (strobe),
        .cycle_tick (cycle_tick),
        .cfg_err    (cfg_err)
    );

    always #5 clk = ~clk;

    // Reference model state: mode 0 idle, 1 arm, 2 run; m_k counts run cycles
    int m_mode = 0;
    int m_k    = 0;
    bit m_stop = 1'b0;
    int m_per  = 10;
    int m_ph [c_num_ch] = '{0, 0};
    int m_hi [c_num_ch] = '{5, 5};

    function automatic bit cfg_valid();
        bit ok;
        ok = (m_per >= 2);
        for (int i = 0; i < c_num_ch; i++) begin
            if (m_hi[i] < 1 || m_hi[i] > m_per - 1 || m_ph[i] > m_per - 1) ok = 1'b0;
        end
        return ok;
    endfunction

    // Model: at each edge, predict the outputs visible after that edge
    always @(posedge clk) begin : model
        exp_t e;
        bit   wr, st, last, ending;
        int   kk;
        e = '0;
        if (!reset_n) begin
            m_mode = 0; m_k = 0; m_stop = 1'b0; m_per = 10;
            for (int i = 0; i < c_num_ch; i++) begin m_ph[i] = 0; m_hi[i] = 5; end
        end else begin
            wr = per_wr || cfg_wr;
            st = start && !stop;
            case (m_mode)
                0: begin
                    if (st) begin
                        e.err = wr || !cfg_valid();
                        if (cfg_valid()) m_mode = 1;
                    end else begin
                        if (per_wr) m_per = int'(cfg_period);
                        if (cfg_wr) begin
                            m_ph[cfg_ch] = int'(cfg_phase);
                            m_hi[cfg_ch] = int'(cfg_high);
                        end
                    end
                end
                1: begin
                    e.err  = wr;
                    m_mode = stop ? 0 : 2;
                    m_k    = 0;
                    m_stop = 1'b0;
                end
                default: begin
                    e.err  = wr;
                    kk     = m_k % m_per;
                    last   = (kk == m_per - 1);
                    ending = last && (m_stop || stop);
                    e.tick = last;
                    if (!ending) begin
                        for (int i = 0; i < c_num_ch; i++) begin
                            e.level[i]  = (((kk - m_ph[i] + m_per) % m_per) < m_hi[i]);
                            e.strobe[i] = (kk == m_ph[i]);
                        end
                    end
                    m_stop = m_stop || stop;
                    m_k    = m_k + 1;
                    if (ending) m_mode = 0;
                end
            endcase
            e.busy = (m_mode != 0);
        end
        sb_q.push_back(e);
    end

    // Monitor: compare each cycle on the falling edge; also checks the
    // asynchronous reset response between edges when signalled
    initial begin : monitor
        exp_t e;
        exp_t a;
        forever begin
            @(negedge clk or ev_async);
            a = {busy, level, strobe, cycle_tick, cfg_err};
            if (($time % 10) != 0) begin
                tests++;
                if (a !== '0) begin
                    fails++;
                    $display("FAIL async_reset t=%0t actual=%b required=0000000", $time, a);
                end
            end else if (sb_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL sb_empty t=%0t actual=%b required=queued_entry", $time, a);
            end else begin
                e = sb_q.pop_front();
                tests++;
                if (a !== e) begin
                    fails++;
                    $display("FAIL outputs t=%0t actual busy=%b lvl=%b stb=%b tick=%b err=%b required busy=%b lvl=%b stb=%b tick=%b err=%b",
                             $time, a.busy, a.level, a.strobe, a.tick, a.err,
                             e.busy, e.level, e.strobe, e.tick, e.err);
                end
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic write_cfg(input logic ch, input int ph, input int hi);
        cfg_wr = 1'b1; cfg_ch = ch; cfg_phase = 8'(ph); cfg_high = 8'(hi);
        tick();
        cfg_wr = 1'b0;
    endtask

    task automatic write_per(input int p);
        per_wr = 1'b1; cfg_period = 8'(p);
        tick();
        per_wr = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (!busy) return;
            tick();
        end
        $display("FAIL wait_idle actual busy=%b required 0 within %0d cycles", busy, budget);
        $fatal(1, "idle timeout");
    endtask

    task automatic stop_and_wait();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        wait_idle(40);
    endtask

    // Stimulus
    initial begin : stim
        tick(3);
        reset_n = 1'b1;
        tick(2);

        // Defaults: 5 high / 5 low, strobe and tick every 10 cycles
        do_start();
        tick(35);
        stop_and_wait();

        // Channel 1 offset, short high
        write_cfg(1'b1, 6, 2);
        do_start();
        tick(25);
        stop_and_wait();

        // Channel 0 wraps across the period boundary
        write_cfg(1'b0, 8, 4);
        do_start();
        tick(25);
        stop_and_wait();

        // Rejected starts
        write_per(1);
        do_start();
        tick(3);
        write_per(10);
        write_cfg(1'b0, 0, 10);
        do_start();
        tick(3);
        write_cfg(1'b0, 0, 0);
        do_start();
        tick(3);
        write_cfg(1'b0, 0, 5);
        start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        tick(3);

        // Start colliding with a write: write dropped, run uses old config
        start = 1'b1; cfg_wr = 1'b1; cfg_ch = 1'b1; cfg_phase = 8'd3; cfg_high = 8'd3;
        tick();
        start = 1'b0; cfg_wr = 1'b0;
        tick(12);

        // Write during RUN rejected, then a mid-period stop
        write_cfg(1'b1, 1, 1);
        tick(4);
        stop_and_wait();
        tick(2);
        do_start();
        tick(15);
        stop_and_wait();

        // Asynchronous reset mid-run, then defaults again
        do_start();
        tick(15);
        #2 reset_n = 1'b0;
        #1 -> ev_async;
        tick();
        reset_n = 1'b1;
        tick(2);
        do_start();
        tick(25);
        stop_and_wait();

        // Randomised traffic
        for (int c = 0; c < 3000; c++) begin
            start      = ($urandom_range(0, 7) == 0);
            stop       = ($urandom_range(0, 29) == 0);
            per_wr     = ($urandom_range(0, 19) == 0);
            cfg_wr     = ($urandom_range(0, 14) == 0);
            cfg_ch     = 1'($urandom_range(0, 1));
            cfg_period = 8'($urandom_range(0, 12));
            cfg_phase  = 8'($urandom_range(0, 12));
            cfg_high   = 8'($urandom_range(0, 12));
            tick();
        end
        start = 1'b0; per_wr = 1'b0; cfg_wr = 1'b0;
        stop_and_wait();
        tick(3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
